// File: rtl/output_arbiter_mesh.sv
`default_nettype none
// ============================================================================
//  Module      : output_arbiter_mesh
//  Description : Output-port arbiter for the XY mesh router. Merges the five
//                per-direction request streams (local, N, E, S, W) onto one
//                output link with packet-granular round-robin arbitration and
//                a one-stage registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter_mesh #(
  parameter int DATA_WIDTH = 32,
  parameter int INPUT_NUM  = 5,
  parameter int PTR_WIDTH  = $clog2(INPUT_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i [INPUT_NUM],
  input  logic [INPUT_NUM-1:0]  last_i,
  input  logic [INPUT_NUM-1:0]  valid_i,
  output logic [INPUT_NUM-1:0]  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  // One extra bit so ptr + offset can exceed INPUT_NUM-1 before wrapping.
  localparam int IDX_W = PTR_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   owner_q, owner_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;

  logic [PTR_WIDTH-1:0]   winner;
  logic                   found;
  logic [IDX_W-1:0]       idx;
  logic [PTR_WIDTH-1:0]   sel;
  logic                   req;
  logic                   out_en;
  logic                   xfer;

  // Next index after p, wrapping INPUT_NUM-1 back to 0.
  function automatic logic [PTR_WIDTH-1:0] inc_ptr(input logic [PTR_WIDTH-1:0] p);
    if (p == PTR_WIDTH'(INPUT_NUM - 1)) begin
      return '0;
    end
    return p + PTR_WIDTH'(1);
  endfunction

  // Round-robin search starting at ptr; scanning offsets from high to low lets
  // the smallest offset with a valid request win.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = INPUT_NUM - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + IDX_W'(k);
      if (idx >= IDX_W'(INPUT_NUM)) begin
        idx = idx - IDX_W'(INPUT_NUM);
      end
      if (valid_i[idx[PTR_WIDTH-1:0]]) begin
        winner = idx[PTR_WIDTH-1:0];
        found  = 1'b1;
      end
    end
  end

  // Grant generation: the owner keeps the grant while locked even if it has
  // stalled, so no other input can slip into the middle of a packet.
  always_comb begin
    out_en  = !valid_q || ready_i;
    sel     = (state_q == ST_LOCKED) ? owner_q : winner;
    req     = (state_q == ST_LOCKED) ? 1'b1 : found;
    ready_o = '0;
    if (!rst_i && req) begin
      ready_o[sel] = out_en;
    end
    xfer = valid_i[sel] && ready_o[sel];
  end

  // FSM next state, pointer/owner update and output register load.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (last_i[sel]) begin
            ptr_d = inc_ptr(sel);
          end else begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer && last_i[sel]) begin
          state_d = ST_IDLE;
          ptr_d   = inc_ptr(owner_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (xfer) begin
      data_d  = data_i[sel];
      last_d  = last_i[sel];
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset discards any lock and in-flight flit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter_mesh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_arbiter_mesh
//  Description : Self-checking bench for output_arbiter_mesh with a
//                cycle-level behavioural model, directed scenarios and
//                randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_arbiter_mesh;

  localparam int DW = 32;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i [N];
  logic [N-1:0]  last_i;
  logic [N-1:0]  valid_i;
  logic [N-1:0]  ready_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          valid_o;
  logic          ready_i;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  bit            m_vo;
  bit            m_lo;
  logic [DW-1:0] m_do;

  output_arbiter_mesh #(
    .DATA_WIDTH (DW),
    .INPUT_NUM  (N),
    .PTR_WIDTH  ($clog2(N))
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_vo     = 1'b0;
    m_lo     = 1'b0;
    m_do     = '0;
  endtask

  // Grant the model predicts for the current inputs.
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    bit           oe;
    int           i;
    r = '0;
    if (rst_i) return r;
    oe = !m_vo || ready_i;
    if (m_locked) begin
      r[m_owner] = oe;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (valid_i[i]) begin
          r[i] = oe;
          break;
        end
      end
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs present this cycle.
  task automatic model_step();
    logic [N-1:0] r;
    int           g;
    if (rst_i) begin
      model_reset();
      return;
    end
    r = exp_ready();
    g = -1;
    for (int i = 0; i < N; i++) if (r[i] && valid_i[i]) g = i;
    if (g >= 0) begin
      m_do = data_i[g];
      m_lo = last_i[g];
      m_vo = 1'b1;
      if (!m_locked) begin
        if (last_i[g]) m_ptr = (g + 1) % N;
        else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else if (last_i[g]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end
    end else if (ready_i) begin
      m_vo = 1'b0;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic cmp_all();
    chk("ready_o", DW'(ready_o), DW'(exp_ready()));
    chk("valid_o", DW'(valid_o), rst_i ? '0 : DW'(m_vo));
    chk("last_o",  DW'(last_o),  rst_i ? '0 : DW'(m_lo));
    chk("data_o",  data_o,       rst_i ? '0 : m_do);
  endtask

  // Wait to mid-cycle and compare.
  task automatic settle();
    @(negedge clk);
    cmp_all();
  endtask

  // Commit the model and move to just after the next rising edge.
  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_i = '0;
    last_i  = '0;
    for (int i = 0; i < N; i++) data_i[i] = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) begin
      settle();
      adv();
    end
    rst_i = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 4, 0};
    rst_i   = 1'b1;
    ready_i = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    do_reset();

    // Single-flit packet on input 2.
    valid_i = 5'b00100; last_i = 5'b00100; data_i[2] = 32'hA;
    settle();
    chk("t1_ready", DW'(ready_o), DW'(5'b00100));
    adv();
    clear_inputs();
    settle();
    chk("t1_data",  data_o, 32'hA);
    chk("t1_last",  DW'(last_o), 32'd1);
    chk("t1_valid", DW'(valid_o), 32'd1);
    chk("t1_ptr",   DW'(m_ptr), 32'd3);
    adv();

    // All inputs stream single-flit packets: grant order 0,1,2,3,4,0.
    do_reset();
    valid_i = '1; last_i = '1;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) data_i[i] = DW'((i << 8) | c);
      settle();
      chk("t2_grant", DW'(onehot_idx(ready_o)), DW'(exp_order[c]));
      if (c > 0) chk("t2_noidle", DW'(valid_o), 32'd1);
      adv();
    end

    // 3-flit packet on input 1 with inputs 0 and 3 contending,
    // including a 4-cycle downstream stall and a 2-cycle owner bubble.
    valid_i = 5'b01011; last_i = 5'b01001;
    data_i[0] = 32'h0F; data_i[3] = 32'h3F; data_i[1] = 32'h1A;
    settle();
    chk("t3_ready_a", DW'(ready_o), DW'(5'b00010));
    adv();
    ready_i = 1'b0; data_i[1] = 32'h1B;
    repeat (4) begin
      settle();
      chk("t4_stall_ready", DW'(ready_o), 32'd0);
      chk("t4_stall_data",  data_o, 32'h1A);
      adv();
    end
    ready_i = 1'b1;
    settle();
    chk("t3_ready_b", DW'(ready_o), DW'(5'b00010));
    adv();
    valid_i = 5'b01001;
    repeat (2) begin
      settle();
      chk("t5_others_blocked", DW'(ready_o & 5'b01001), 32'd0);
      adv();
    end
    chk("t5_bubble", DW'(valid_o), 32'd0);
    valid_i = 5'b01011; last_i = 5'b01011; data_i[1] = 32'h1C;
    settle();
    chk("t3_ready_c", DW'(ready_o), DW'(5'b00010));
    adv();
    settle();
    chk("t3_next_grant", DW'(ready_o), DW'(5'b01000));
    chk("t3_data_c", data_o, 32'h1C);
    adv();

    // Asynchronous reset in the middle of a packet on input 4.
    do_reset();
    valid_i = 5'b10000; last_i = '0; data_i[4] = 32'h4A;
    settle();
    adv();
    data_i[4] = 32'h4B;
    settle();
    #2 rst_i = 1'b1;
    #1;
    chk("t6_valid_async", DW'(valid_o), 32'd0);
    chk("t6_ready_async", DW'(ready_o), 32'd0);
    chk("t6_data_async",  data_o, 32'd0);
    model_reset();
    @(posedge clk); #1;
    valid_i = 5'b10001; last_i = '1; data_i[0] = 32'h0A;
    settle();
    adv();
    rst_i = 1'b0;
    settle();
    chk("t6_ptr0_wins", DW'(ready_o), DW'(5'b00001));
    adv();

    // Randomized traffic with random backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      valid_i = N'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) valid_i = valid_i & N'($urandom_range(0, 31));
      for (int i = 0; i < N; i++) begin
        last_i[i] = ($urandom_range(0, 9) < 4);
        data_i[i] = $urandom;
      end
      ready_i = ($urandom_range(0, 3) != 0);
      rst_i   = ($urandom_range(0, 499) == 0);
      settle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
